// File: rtl/bram_debug_loader_if.sv
// Host-side bundle for the BRAM debug loader: command channel, load
// stream (host -> BRAM) and dump stream (BRAM -> host).
interface bram_debug_loader_if #(
  parameter int CNT_W = 13
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [31:0]      cmd_base;
  logic [CNT_W-1:0] cmd_count;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [31:0]      out_addr;

  // Host side: issues commands, supplies load data, consumes dump data.
  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_count, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, out_addr
  );

  // Loader side.
  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_count, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, out_addr
  );
endinterface

// File: rtl/bram_debug_loader.sv
// Hardware master for the 32-bit BRAM debug port of the cache. A command
// either streams words into BRAM (load) or streams BRAM contents out with
// their byte addresses (dump). All outputs come straight from flops.
module bram_debug_loader #(
  parameter int WORDS = 4096,
  parameter int CNT_W = 13
) (
  input  logic               CPU_CLK,
  input  logic               CPU_RST,
  bram_debug_loader_if.slave bus,
  output logic [31:0]        DBG_A2,
  output logic [31:0]        DBG_WD2,
  output logic [3:0]         DBG_WE2,
  input  logic [31:0]        DBG_RD2,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_RD_OUT  = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] WORDS_C   = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] ONE_C     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] ZERO_C    = {CNT_W{1'b0}};
  localparam logic [31:0]      WORD_STEP = 32'd4;
  localparam logic [31:0]      WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]       WE_ALL    = 4'b1111;
  localparam logic [3:0]       WE_NONE   = 4'b0000;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [31:0]      a2_q, a2_d;
  logic [31:0]      wd2_q, wd2_d;
  logic [3:0]       we2_q, we2_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [31:0]      out_addr_q, out_addr_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] cmd_words_s;
  logic [31:0]      cmd_addr_s;
  logic             in_beat_s;
  logic             out_beat_s;

  // Decode the offered command and the stream handshakes.
  always_comb begin
    cmd_words_s = (bus.cmd_count > WORDS_C) ? WORDS_C : bus.cmd_count;
    cmd_addr_s  = bus.cmd_base & WORD_MASK;
    in_beat_s   = bus.in_valid && in_ready_q;
    out_beat_s  = bus.out_ready && out_valid_q && (state_q == ST_RD_OUT);
  end

  // Next-state and next-output logic; write enable falls back to idle each cycle.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    a2_d        = a2_q;
    wd2_d       = wd2_q;
    we2_d       = WE_NONE;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_addr_d  = out_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          addr_d = cmd_addr_s;
          rem_d  = cmd_words_s;
          if (cmd_words_s == ZERO_C) begin
            state_d = ST_DONE;
          end else if (!bus.cmd_op) begin
            state_d = ST_LOAD;
          end else begin
            a2_d    = cmd_addr_s;
            state_d = ST_RD_ADDR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LOAD: begin
        if (in_beat_s) begin
          a2_d   = addr_q;
          wd2_d  = bus.in_data;
          we2_d  = WE_ALL;
          addr_d = addr_q + WORD_STEP;
          rem_d  = rem_q - ONE_C;
          if (rem_q == ONE_C) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end

      // BRAM samples DBG_A2 at the end of this cycle.
      ST_RD_ADDR: begin
        state_d = ST_RD_DATA;
      end

      ST_RD_DATA: begin
        out_data_d  = DBG_RD2;
        out_addr_d  = a2_q;
        out_valid_d = 1'b1;
        state_d     = ST_RD_OUT;
      end

      ST_RD_OUT: begin
        if (out_beat_s) begin
          out_valid_d = 1'b0;
          rem_d       = rem_q - ONE_C;
          if (rem_q == ONE_C) begin
            state_d = ST_DONE;
          end else begin
            a2_d    = a2_q + WORD_STEP;
            state_d = ST_RD_ADDR;
          end
        end else begin
          state_d = ST_RD_OUT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are registered copies of the next state's decode.
    cmd_ready_d = (state_d == ST_IDLE);
    in_ready_d  = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State register; reset aborts any command without a done pulse.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      addr_q      <= 32'h0000_0000;
      rem_q       <= ZERO_C;
      a2_q        <= 32'h0000_0000;
      wd2_q       <= 32'h0000_0000;
      we2_q       <= WE_NONE;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
      out_addr_q  <= 32'h0000_0000;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      a2_q        <= a2_d;
      wd2_q       <= wd2_d;
      we2_q       <= we2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_addr_q  <= out_addr_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign DBG_A2        = a2_q;
  assign DBG_WD2       = wd2_q;
  assign DBG_WE2       = we2_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: doc/bram_debug_loader.md
# bram_debug_loader

Synthesizable master for the 32-bit BRAM debug port (A2/WD2/WE2/RD2) of the RV32ICore data or instruction cache. It does in hardware what the simulation bench does by hand: it takes a load/dump command, streams words into BRAM over a valid/ready input, and streams BRAM contents out over a valid/ready output. One instance sits on each cache debug port, with a host link such as a UART bridge in front. The CPU is held in reset by the system while the loader is busy.

## Interface
- WORDS, 4096: BRAM depth in 32-bit words; commands longer than this saturate to WORDS.
- CNT_W, 13: width of cmd_count, enough to encode WORDS.
- CPU_CLK  in  1  single clock; every register is clocked on its rising edge.
- CPU_RST  in  1  reset, asynchronous and active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  1  0 = load (write BRAM), 1 = dump (read BRAM).
- cmd_base  in  32  byte start address; bits [1:0] are ignored and forced to 0.
- cmd_count  in  CNT_W  number of words.
- in_valid / in_ready / in_data  in/out/in  1/1/32  load data stream.
- out_valid / out_ready  out/in  1/1  dump data stream.
- out_data / out_addr  out  32/32  dumped word and its byte address.
- DBG_A2  out  32  BRAM debug address, registered.
- DBG_WD2  out  32  BRAM debug write data, registered.
- DBG_WE2  out  4  BRAM byte write enables, registered; the value is 4'b1111 or 4'b0000.
- DBG_RD2  in  32  BRAM read data, valid one cycle after BRAM samples DBG_A2.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a command completes.

## Operation
- States: IDLE, LOAD, RD_ADDR, RD_DATA, RD_OUT, DONE.
- Reset (asynchronous, immediate): state=IDLE, DBG_A2=0, DBG_WD2=0, DBG_WE2=0, out_valid=0, out_data=0, out_addr=0, done=0, in_ready=0, busy=0, internal addr/remaining=0. A command in flight is aborted with no done pulse.
- IDLE: cmd_ready=1. On cmd_valid, latch addr={cmd_base[31:2],2'b00} and remaining=min(cmd_count,WORDS).
  - If remaining is 0, go to DONE.
  - Else if op=0, go to LOAD.
  - Else (op=1), set DBG_A2<=addr and go to RD_ADDR.
- LOAD: in_ready=1.
  - On an in_valid&&in_ready beat: DBG_A2<=addr, DBG_WD2<=in_data, DBG_WE2<=4'b1111, addr<=addr+4, remaining<=remaining-1. The last beat goes to DONE.
  - In any cycle without a beat, DBG_WE2<=0.
- RD_ADDR: DBG_WE2=0. The BRAM samples DBG_A2 at the end of this cycle. Go to RD_DATA.
- RD_DATA: out_data<=DBG_RD2, out_addr<=DBG_A2, out_valid<=1. Go to RD_OUT.
- RD_OUT: hold out_valid, out_data and out_addr stable until out_ready. On the handshake, out_valid<=0 and remaining<=remaining-1.
  - If remaining was 1, go to DONE.
  - Else set DBG_A2<=DBG_A2+4 and go to RD_ADDR.
- DONE: done=1 for exactly one cycle and DBG_WE2=0. Go to IDLE.
- Address arithmetic is 32-bit modulo 2^32; FFFFFFFC+4 wraps to 00000000.
- No cmd_op value is illegal. in_valid outside LOAD is ignored (in_ready=0). out_ready outside RD_OUT is ignored.

## Timing
- Load latency: a beat accepted at edge E drives DBG_A2/WD2/WE2 during the cycle after E, and the BRAM writes at edge E+1.
- Load throughput is 1 word/cycle when in_valid stays high. An N-word load with no gaps has done high N+1 cycles after command accept.
- Dump latency: command accepted at edge E0, out_valid high after E0+2. Throughput is 3 cycles per word when out_ready is held high.
- Count 0: done is high in the cycle after accept, and there is no BRAM access.
- cmd_ready returns to 1 in the cycle after done. A back-to-back command is accepted at the edge that ends that first IDLE cycle.

## Test plan
- Load 4 words (base 0x00000000, data 11111111/22222222/33333333/44444444, in_valid held high) -> DBG_WE2=1111 for 4 consecutive cycles, DBG_A2=0,4,8,C with matching WD2, done 5 cycles after accept. The BRAM model holds the data.
- Dump the same 4 words from a 1-cycle-latency BRAM model with out_ready=1 -> out_addr 0,4,8,C, out_data matches, out_valid every 3rd cycle, a single done pulse.
- Dump with out_ready low for 5 cycles on word 2 -> out_valid, out_data and out_addr are stable through the stall, and there is no DBG_A2 change until the handshake.
- Load with in_valid toggling 1,0,0,1 -> DBG_WE2 is low in the gap cycles, and the addresses stay contiguous (0,4).
- cmd_count=0 -> done 1 cycle after accept, DBG_WE2 never asserted. base=FFFFFFFE, count=2, load -> DBG_A2 = FFFFFFFC then 00000000.
- Assert CPU_RST mid-load after 2 beats (between clock edges) -> DBG_WE2=0 and busy=0 immediately, no done pulse. After release, cmd_ready=1 and a new command is accepted normally.
